// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: streams two WIDTH-bit operands LSB-first through an
// external combinational full adder, keeping the running carry in a register.
module serial_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c1,
  input  logic             fa_f,
  input  logic             fa_c2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] F,
  output logic             Cout,
  output logic             V
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_PEN  = CNT_W'(WIDTH - 2);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             c_msb_q, c_msb_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] s_sh_q, s_sh_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic             cout_q, cout_d;
  logic             v_q, v_d;
  logic             done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      c_msb_q <= 1'b0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      f_q     <= '0;
      cout_q  <= 1'b0;
      v_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      c_msb_q <= c_msb_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      f_q     <= f_d;
      cout_q  <= cout_d;
      v_q     <= v_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    c_msb_d = c_msb_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    f_d     = f_q;
    cout_d  = cout_q;
    v_d     = v_q;
    done_d  = 1'b0;
    fa_a    = 1'b0;
    fa_b    = 1'b0;
    fa_c1   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = A;
          b_sh_d  = B;
          carry_d = Cin;
          cnt_d   = '0;
          s_sh_d  = '0;
          f_d     = '0;
          cout_d  = 1'b0;
          v_d     = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Adder loop stays combinational: register bits out, fa_f/fa_c2 back in.
        fa_a    = a_sh_q[0];
        fa_b    = b_sh_q[0];
        fa_c1   = carry_q;
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        s_sh_d  = {fa_f, s_sh_q[WIDTH-1:1]};
        carry_d = fa_c2;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_PEN) c_msb_d = fa_c2;
        if (cnt_q == CNT_LAST) begin
          f_d     = {fa_f, s_sh_q[WIDTH-1:1]};
          cout_d  = fa_c2;
          v_d     = fa_c2 ^ c_msb_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign F    = f_q;
  assign Cout = cout_q;
  assign V    = v_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: models the full-adder cell, checks every operation
// against plain integer addition and per-bit carries.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start, Cin;
  logic [W-1:0] A, B;
  logic         fa_a, fa_b, fa_c1, fa_f, fa_c2;
  logic         busy, done, Cout, V;
  logic [W-1:0] F;

  int n_cmp = 0;
  int n_err = 0;
  logic [W+1:0] exp_q[$];  // {V, Cout, F}

  serial_add_ctrl #(.WIDTH(W), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Cin(Cin),
    .fa_a(fa_a), .fa_b(fa_b), .fa_c1(fa_c1), .fa_f(fa_f), .fa_c2(fa_c2),
    .busy(busy), .done(done), .F(F), .Cout(Cout), .V(V)
  );

  // The shared full-adder cell
  assign fa_f  = fa_a ^ fa_b ^ fa_c1;
  assign fa_c2 = (fa_a & fa_b) | (fa_a & fa_c1) | (fa_b & fa_c1);

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin);
    int unsigned sum;
    logic [W-1:0] f;
    logic v;
    sum = int'(a) + int'(b) + int'(cin);
    f   = sum[W-1:0];
    v   = (a[W-1] == b[W-1]) && (f[W-1] != a[W-1]);
    return {v, sum[W], f};
  endfunction

  function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic cin, input int i);
    int unsigned mask, s;
    mask = (32'd1 << i) - 32'd1;
    s = (int'(a) & mask) + (int'(b) & mask) + int'(cin);
    return s[i];
  endfunction

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    A = a; B = b; Cin = cin; start = 1'b1;
    exp_q.push_back(model(a, b, cin));
    tick();
    start = 1'b0;
    A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
  endtask

  task automatic check_result(input string tag);
    logic [W+1:0] e;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
    if (exp_q.size() == 0) begin
      check({tag, "_no_expected"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_F"}, 32'(F), 32'(e[W-1:0]));
      check({tag, "_Cout"}, 32'(Cout), 32'(e[W]));
      check({tag, "_V"}, 32'(V), 32'(e[W+1]));
    end
  endtask

  // Called right after the accepting edge: walks all W bit cycles, then checks done.
  task automatic finish_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin);
    for (int i = 0; i < W; i++) begin
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_done_early"}, 32'(done), 32'd0);
      check({tag, "_fa_a"}, 32'(fa_a), 32'(a[i]));
      check({tag, "_fa_b"}, 32'(fa_b), 32'(b[i]));
      check({tag, "_fa_c1"}, 32'(fa_c1), 32'(carry_into(a, b, cin, i)));
      tick();
    end
    check_result(tag);
  endtask

  task automatic full_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin);
    logic [W+1:0] e;
    e = model(a, b, cin);
    start_op(a, b, cin);
    finish_op(tag, a, b, cin);
    tick();
    check({tag, "_done_drop"}, 32'(done), 32'd0);
    check({tag, "_F_hold"}, 32'(F), 32'(e[W-1:0]));
  endtask

  initial begin
    logic [W-1:0] ra, rb, ra2, rb2;
    logic rc, rc2;
    int n_done;

    rst = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
    tick(); tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_F", 32'(F), 32'd0);
    check("rst_Cout", 32'(Cout), 32'd0);
    check("rst_V", 32'(V), 32'd0);
    check("rst_fa", 32'({fa_a, fa_b, fa_c1}), 32'd0);
    rst = 1'b0;
    tick();

    full_op("d5a3c", 8'h5A, 8'h3C, 1'b0);
    full_op("dff01", 8'hFF, 8'h01, 1'b0);
    full_op("d7f00", 8'h7F, 8'h00, 1'b1);
    full_op("d8080", 8'h80, 8'h80, 1'b0);
    full_op("dffff", 8'hFF, 8'hFF, 1'b1);

    for (int k = 0; k < 20; k++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom_range(0, 1));
      full_op("rnd", ra, rb, rc);
      repeat ($urandom_range(0, 2)) tick();
    end

    // Start while busy is ignored; exactly one done with the first operands
    ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
    start_op(ra, rb, rc);
    repeat (3) tick();
    A = ~ra; B = ~rb; start = 1'b1;
    tick();
    start = 1'b0;
    n_done = 0;
    for (int i = 0; i < 3 * W; i++) begin
      if (done) begin
        n_done++;
        check_result("ign");
      end
      tick();
    end
    check("ign_done_count", 32'(n_done), 32'd1);
    check("ign_idle", 32'(busy), 32'd0);

    // Reset mid-run aborts with no done
    start_op(8'h12, 8'h34, 1'b1);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_F", 32'(F), 32'd0);
    check("abort_Cout", 32'(Cout), 32'd0);
    check("abort_V", 32'(V), 32'd0);
    n_done = 0;
    for (int i = 0; i < 2 * W; i++) begin
      if (done) n_done++;
      tick();
    end
    check("abort_no_done", 32'(n_done), 32'd0);
    full_op("post_abort", 8'hA5, 8'h5B, 1'b0);

    // start held high across done: back-to-back operations
    ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
    ra2 = W'($urandom); rb2 = W'($urandom); rc2 = 1'($urandom);
    A = ra; B = rb; Cin = rc; start = 1'b1;
    exp_q.push_back(model(ra, rb, rc));
    tick();
    A = ra2; B = rb2; Cin = rc2;
    for (int i = 0; i < W; i++) begin
      check("b2b_busy1", 32'(busy), 32'd1);
      tick();
    end
    check_result("b2b1");
    exp_q.push_back(model(ra2, rb2, rc2));
    tick();
    start = 1'b0;
    A = ~ra2; B = ~rb2;
    check("b2b_done_drop", 32'(done), 32'd0);
    check("b2b_F_clr", 32'(F), 32'd0);
    check("b2b_Cout_clr", 32'(Cout), 32'd0);
    check("b2b_V_clr", 32'(V), 32'd0);
    finish_op("b2b2", ra2, rb2, rc2);
    tick();
    check("b2b_end_done", 32'(done), 32'd0);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
